// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the MIPS pipeline hazard/forwarding controller.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_t;

    // Only these opcodes read rt as a source; elsewhere rt is a destination or unused.
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
    endfunction

    function automatic logic reg_match(input logic we, input logic [4:0] dst,
                                       input logic [4:0] src);
        return we && (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Single-operand forwarding selector; EX/MEM result wins over the WB value.
module fwd_select
    import mips_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic       mem_reg_write,
    input  logic [4:0] mem_rd,
    input  logic       wb_reg_write,
    input  logic [4:0] wb_rd,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        if (reg_match(mem_reg_write, mem_rd, src)) begin
            sel = FWD_MEM;
        end else if (reg_match(wb_reg_write, wb_rd, src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard detection, forwarding and PC sequencing for the 5-stage MIPS pipeline,
// with saturating stall/flush statistics and a sticky stall-limit error flag.
module pipeline_hazard_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int INIT_CYCLES = 3,
    parameter int CNT_W       = 16,
    parameter int MAX_STALL   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      id_inst,
    input  logic             eq_flag,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [4:0]       ex_dest,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic             mem_mem_read,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_rd,
    input  logic             wb_reg_write,
    input  logic [4:0]       wb_rd,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             if_flush,
    output logic [1:0]       pc_src,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             hazard_err
);

    localparam int INIT_W = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES);
    localparam int RUN_W  = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);

    ctrl_state_t       state;
    logic [INIT_W-1:0] init_cnt;
    logic [RUN_W-1:0]  stall_run;

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       run;
    logic       lu_hazard;
    logic       br_hazard;
    logic       stall;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;
    logic       unused_bits;

    assign op  = id_inst[31:26];
    assign rs  = id_inst[25:21];
    assign rt  = id_inst[20:16];
    assign run = (state == RUN);

    // The load's memory-read flag in MEM and the immediate field play no part here.
    assign unused_bits = ^{mem_mem_read, id_inst[15:0]};

    // A load in EX cannot forward to the instruction now in ID; a beq compares in ID
    // without forwarding, so any pending EX or MEM write to its operands must drain.
    always_comb begin
        lu_hazard = ex_mem_read && (reg_match(1'b1, ex_dest, rs) ||
                                    (uses_rt(op) && reg_match(1'b1, ex_dest, rt)));
        br_hazard = (op == OP_BEQ) &&
                    (reg_match(ex_reg_write, ex_dest, rs) ||
                     reg_match(ex_reg_write, ex_dest, rt) ||
                     reg_match(mem_reg_write, mem_rd, rs) ||
                     reg_match(mem_reg_write, mem_rd, rt));
        stall     = run && (lu_hazard || br_hazard);
    end

    // Outputs default to the quiet pipeline used during reset and INIT.
    always_comb begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        if_flush   = 1'b1;
        bubble     = 1'b1;
        pc_src     = PC_PLUS4;
        if (run) begin
            if (stall) begin
                if_flush = 1'b0;
            end else if (op == OP_J) begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
                bubble     = 1'b0;
                pc_src     = PC_JUMP;
            end else if ((op == OP_BEQ) && eq_flag) begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
                bubble     = 1'b0;
                pc_src     = PC_BRANCH;
            end else begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
                bubble     = 1'b0;
                if_flush   = 1'b0;
            end
        end
    end

    fwd_select u_fwd_a (
        .src           (ex_rs),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .sel           (fwd_a_raw)
    );

    fwd_select u_fwd_b (
        .src           (ex_rt),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .sel           (fwd_b_raw)
    );

    assign fwd_a = run ? fwd_a_raw : FWD_RF;
    assign fwd_b = run ? fwd_b_raw : FWD_RF;

    // INIT holds the pipeline flushed for INIT_CYCLES edges; RUN keeps the statistics
    // and the consecutive-stall run that arms the sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= INIT;
            init_cnt   <= INIT_W'(INIT_CYCLES - 1);
            stall_run  <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            hazard_err <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    if (init_cnt == '0) begin
                        state <= RUN;
                    end else begin
                        init_cnt <= init_cnt - INIT_W'(1);
                    end
                end
                RUN: begin
                    if (stall) begin
                        if (stall_cnt != {CNT_W{1'b1}}) begin
                            stall_cnt <= stall_cnt + CNT_W'(1);
                        end
                        if (stall_run == RUN_W'(MAX_STALL)) begin
                            hazard_err <= 1'b1;
                        end else begin
                            stall_run <= stall_run + RUN_W'(1);
                        end
                    end else begin
                        stall_run <= '0;
                    end
                    if (if_flush && (flush_cnt != {CNT_W{1'b1}})) begin
                        flush_cnt <= flush_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard, forwarding and PC-sequencing controller for the 5-stage MIPS pipeline.
- Drives the pipeline datapath's PCWrite, IFToIDWrite, IF_Flush, PCSrc and ForwardingUnitA/B inputs from the stage register/hazard signals the datapath exports.
- Holds the pipeline quiet after reset.
- Detects load-use and branch-operand hazards in ID and redirects the PC on beq/j.
- Keeps saturating stall/flush statistics.

Parameters:
- INIT_CYCLES, 3, cycles after reset release during which the pipeline is flushed and the PC is frozen.
- CNT_W, 16, width of the stall_cnt and flush_cnt statistics counters.
- MAX_STALL, 3, consecutive-stall limit; exceeding it sets hazard_err.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_inst  in  32  instOut (ID-stage instruction).
- eq_flag  in  1  ID comparator result (eqFlag).
- ex_mem_read  in  1  IDToEXMemRead.
- ex_reg_write  in  1  ID/EX RegWrite.
- ex_dest  in  5  ID/EX RegDst-selected destination.
- ex_rs, ex_rt  in  5  IDToEXRs, IDToEXRt.
- mem_mem_read  in  1  EXToMEMMemRead.
- mem_reg_write  in  1  EXToMEMRegWrite.
- mem_rd  in  5  EXToMEMRd.
- wb_reg_write  in  1  MEMToWBRegWrite.
- wb_rd  in  5  MemToWBRd.
- pc_write  out  1  PCWrite.
- ifid_write  out  1  IFToIDWrite.
- if_flush  out  1  IF_Flush.
- pc_src  out  2  00 = PC+4, 01 = branch target, 10 = jump target.
- fwd_a, fwd_b  out  2  00 = register file, 01 = WB (mux6out), 10 = EX/MEM result.
- bubble  out  1  zero the control word entering ID/EX.
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- flush_cnt  out  CNT_W  saturating count of taken redirects.
- hazard_err  out  1  sticky; set when consecutive stalls exceed MAX_STALL.

Behaviour:
- Reset (reset = 0, asynchronous): state = INIT, init counter = INIT_CYCLES-1, stall run = 0, stall_cnt = flush_cnt = 0, hazard_err = 0.
- Outputs during reset: pc_write = 0, ifid_write = 0, if_flush = 1, bubble = 1, pc_src = 00, fwd_a = fwd_b = 00.
- Outputs are combinational from the registered state plus the current inputs; zero-cycle latency is required so hazards take effect in the cycle they are detected.
- INIT: outputs as in reset. Decrement the init counter each cycle; move to RUN after it reaches 0, so exactly INIT_CYCLES cycles are spent in INIT. Stage inputs are ignored in INIT.
- RUN decode: op = id_inst[31:26], rs = [25:21], rt = [20:16].
- uses_rt is true for op 0 (R-type), 4 (beq) and 43 (sw).
- Register 0 never matches any destination.
- Hazard conditions, evaluated in RUN:
  - lu: ex_mem_read && ex_dest == rs, or ex_mem_read && uses_rt && ex_dest == rt.
  - br: op == 4, and one of the following matches rs or rt:
    - (ex_reg_write, ex_dest)
    - (mem_reg_write, mem_rd)
  - The ID comparator has no forwarding; writes through the WB stage are visible via the negedge register-file write.
- RUN priority, highest first:
  - Stall (lu or br): pc_write = 0, ifid_write = 0, bubble = 1, if_flush = 0, pc_src = 00.
  - Else op == 2 (j): pc_src = 10, if_flush = 1, pc_write = 1, ifid_write = 1.
  - Else op == 4 and eq_flag: pc_src = 01, if_flush = 1, pc_write = 1, ifid_write = 1.
  - Else: pc_src = 00, pc_write = 1, ifid_write = 1, bubble = 0, if_flush = 0.
- Forwarding (RUN only, independent of stall), shown for fwd_a/ex_rs; fwd_b uses ex_rt identically:
  - 10 if mem_reg_write && mem_rd != 0 && mem_rd == ex_rs.
  - Else 01 if wb_reg_write && wb_rd != 0 && wb_rd == ex_rs.
  - Else 00.
  - EX/MEM has priority when both match.
- Statistics:
  - stall_cnt increments on each RUN stall cycle.
  - flush_cnt increments on each RUN cycle with if_flush = 1.
  - Both saturate at all-ones; neither counts in INIT.
- Stall run counter:
  - Increments on each stall cycle and clears on each non-stall cycle.
  - When a stall occurs with the run already equal to MAX_STALL, set hazard_err. hazard_err stays set until reset.
  - The run counter saturates at MAX_STALL.
- Reset asserted mid-stall or mid-redirect: immediate asynchronous return to the reset state; no partial counts are retained.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants OP_RTYPE = 0, OP_J = 2, OP_BEQ = 4, OP_LW = 35, OP_SW = 43.
  - PCSrc encodings PC_PLUS4 / PC_BRANCH / PC_JUMP.
  - Forwarding encodings FWD_RF / FWD_WB / FWD_MEM.
  - State enum INIT / RUN.
- One sub-module, fwd_select: purely combinational single-operand forwarding priority, instantiated twice (A, B).

Test Plan:
- Reset low 2 cycles, then release with INIT_CYCLES = 3 → pc_write = 0 and if_flush = 1 for exactly 3 clk edges; cycle 4 gives pc_write = 1, pc_src = 00.
- lw $2 in EX (ex_mem_read = 1, ex_dest = 2), id_inst = add $3,$2,$1 → one cycle with pc_write = 0, ifid_write = 0, bubble = 1; stall_cnt = 1.
- beq $1,$2 in ID while EX writes $2 → 2 stall cycles (EX then MEM); third cycle with eq_flag = 1 → pc_src = 01, if_flush = 1, flush_cnt = 1.
- id_inst = j 0x40 → pc_src = 10, if_flush = 1, no stall; beq with eq_flag = 0 → pc_src = 00, if_flush = 0.
- ex_rs = ex_rt = 5, mem_rd = 5, wb_rd = 5, both write enables = 1 → fwd_a = fwd_b = 10. With mem_reg_write = 0 → 01. With rd = 0 → 00.
- Hold br hazard for 5 cycles (MAX_STALL = 3) → hazard_err rises on the 4th stall cycle and stays 1 until reset; stall_cnt with CNT_W = 2 saturates at 3.
